// File: rtl/pll_supervisor_if.sv
// Signal bundle between the PLL supervisor and the PLL / system-reset side.
// master = supervisor, slave = PLL and reset consumers.
`timescale 1ns/1ps
interface pll_supervisor_if;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned LLC_W   = 8;

  logic               pll_locked;
  logic               retry_req;
  logic               pll_reset;
  logic               sys_rst_n;
  logic               fault;
  logic [STATE_W-1:0] state;
  logic [LLC_W-1:0]   lock_loss_cnt;

  modport master (
    input  pll_locked,
    input  retry_req,
    output pll_reset,
    output sys_rst_n,
    output fault,
    output state,
    output lock_loss_cnt
  );

  modport slave (
    output pll_locked,
    output retry_req,
    input  pll_reset,
    input  sys_rst_n,
    input  fault,
    input  state,
    input  lock_loss_cnt
  );
endinterface

// File: rtl/pll_supervisor.sv
// PLL bring-up sequencer: pulses PLL reset, waits for lock with timeout/retries,
// qualifies lock stability, then releases sys_rst_n and watches for lock loss.
`timescale 1ns/1ps
module pll_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 27_000,
  parameter int unsigned STABLE_CYCLES  = 2_700,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              ext_clk,
  input  logic              rst_n,
  pll_supervisor_if.master  pll
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LLC_W   = 8;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  // Reject parameter sets the counter or retry field cannot represent.
  if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_cycles
    $error("pll_supervisor: cycle parameters must be >= 1");
  end
  if (MAX_RETRIES > 15) begin : g_bad_retries
    $error("pll_supervisor: MAX_RETRIES must be in 0..15");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("pll_supervisor: CNT_W must be in 1..32");
  end
  if (64'(PLL_RST_CYCLES) > CNT_MAX || 64'(LOCK_TIMEOUT) > CNT_MAX ||
      64'(STABLE_CYCLES) > CNT_MAX) begin : g_cnt_too_narrow
    $error("pll_supervisor: CNT_W too narrow for cycle parameters");
  end

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [LLC_W-1:0]   LLC_SAT      = '1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic [LLC_W-1:0]   loss_q, loss_d;
  logic [1:0]         sync_q;
  logic               pll_reset_q, pll_reset_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               fault_q, fault_d;
  logic               lk;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll.pll_locked};
    end
  end

  assign lk = sync_q[1];

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      fault_q     <= fault_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    loss_d    = loss_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lock is tested before the timeout so a coincident lock wins.
      S_WAIT_LOCK: begin
        if (lk) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retries_q < RETRY_LIMIT) begin
            retries_d = retries_q + RETRY_W'(1);
            state_d   = S_RESET_PLL;
          end else begin
            state_d = S_FAULT;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Any unlocked cycle, including the last one, abandons the window.
      S_STABILIZE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          retries_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RUN: begin
        if (!lk) begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          if (loss_q != LLC_SAT) begin
            loss_d = loss_q + LLC_W'(1);
          end
        end
      end

      S_FAULT: begin
        if (pll.retry_req) begin
          state_d   = S_RESET_PLL;
          cnt_d     = '0;
          retries_d = '0;
        end
      end

      default: begin
        state_d = S_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    pll_reset_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  assign pll.pll_reset     = pll_reset_q;
  assign pll.sys_rst_n     = sys_rst_n_q;
  assign pll.fault         = fault_q;
  assign pll.state         = state_q;
  assign pll.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: vector table for bring-up, glitch and
// boundary cases, plus hand sequences for fault/retry, repeated loss and async reset.
`timescale 1ns/1ps
module tb_pll_supervisor;

  localparam int unsigned PLL_RST_CYCLES = 4;
  localparam int unsigned LOCK_TIMEOUT   = 20;
  localparam int unsigned STABLE_CYCLES  = 8;
  localparam int unsigned MAX_RETRIES    = 2;
  localparam int ATTEMPT  = 24;   // 4 reset cycles + 20 wait cycles
  localparam int FAULT_AT = 72;   // three failed attempts

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pll_supervisor_if pif();

  pll_supervisor #(
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES),
    .CNT_W          (16)
  ) dut (
    .ext_clk (clk),
    .rst_n   (rst_n),
    .pll     (pif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         lk;
    bit         rq;
    int         ncyc;
    logic [2:0] st;
    bit         pr;
    bit         srn;
    bit         flt;
    logic [7:0] llc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit lk, bit rq, int n, logic [2:0] st,
                              bit pr, bit srn, bit flt, logic [7:0] llc);
    vec_t v;
    v.rst = rst; v.lk = lk; v.rq = rq; v.ncyc = n;
    v.st = st; v.pr = pr; v.srn = srn; v.flt = flt; v.llc = llc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string tag, input logic [2:0] st, input bit pr,
                       input bit srn, input bit flt, input logic [7:0] llc);
    checks++;
    if (pif.state !== st || pif.pll_reset !== pr || pif.sys_rst_n !== srn ||
        pif.fault !== flt || pif.lock_loss_cnt !== llc) begin
      errors++;
      $display("FAIL %s: got state=%0d pll_reset=%b sys_rst_n=%b fault=%b llc=%0d, want state=%0d pll_reset=%b sys_rst_n=%b fault=%b llc=%0d",
               tag, pif.state, pif.pll_reset, pif.sys_rst_n, pif.fault, pif.lock_loss_cnt,
               st, pr, srn, flt, llc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    pif.pll_locked = 1'b0;
    pif.retry_req  = 1'b0;
    @(negedge clk);
    check("reset", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(negedge clk);
      if (pif.state === s) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: state=%0d after %0d cycles, want %0d", tag, pif.state, max_cyc, s);
    end
  endtask

  task automatic run_to_fault(input string tag);
    logic [2:0] st;
    for (int k = 0; k <= FAULT_AT; k++) begin
      if (k == FAULT_AT)                          st = 3'd4;
      else if ((k % ATTEMPT) < int'(PLL_RST_CYCLES)) st = 3'd0;
      else                                        st = 3'd1;
      check($sformatf("%s k=%0d", tag, k), st, st != 3'd1, 1'b0, k == FAULT_AT, 8'd0);
      if (k < FAULT_AT) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_llc;
    pif.pll_locked = 1'b0;
    pif.retry_req  = 1'b0;

    //   rst lk rq  n   st pr srn flt llc
    // Normal bring-up, retry ignored in RUN, loss and relock
    add(1, 0, 0,  3, 0, 1, 0, 0, 0);
    add(0, 0, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 10, 1, 0, 0, 0, 0);
    add(0, 1, 0,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0,  1, 2, 0, 0, 0, 0);
    add(0, 1, 0,  7, 2, 0, 0, 0, 0);
    add(0, 1, 0,  1, 3, 0, 1, 0, 0);
    add(0, 1, 1,  1, 3, 0, 1, 0, 0);
    add(0, 1, 0,  3, 3, 0, 1, 0, 0);
    add(0, 0, 0,  2, 3, 0, 1, 0, 0);
    add(0, 0, 0,  1, 0, 1, 0, 0, 1);
    add(0, 0, 0,  3, 0, 1, 0, 0, 1);
    add(0, 0, 0,  1, 1, 0, 0, 0, 1);
    add(0, 1, 0,  2, 1, 0, 0, 0, 1);
    add(0, 1, 0,  1, 2, 0, 0, 0, 1);
    add(0, 1, 0,  7, 2, 0, 0, 0, 1);
    add(0, 1, 0,  1, 3, 0, 1, 0, 1);
    // Glitchy lock: 5 high, 1 low, then steady
    add(1, 0, 0,  4, 1, 0, 0, 0, 0);
    add(0, 1, 0,  3, 2, 0, 0, 0, 0);
    add(0, 1, 0,  2, 2, 0, 0, 0, 0);
    add(0, 0, 0,  1, 2, 0, 0, 0, 0);
    add(0, 1, 0,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0,  1, 2, 0, 0, 0, 0);
    add(0, 1, 0,  7, 2, 0, 0, 0, 0);
    add(0, 1, 0,  1, 3, 0, 1, 0, 0);
    // Lock coincident with timeout, then drop on the final stability cycle
    add(1, 0, 0, 21, 1, 0, 0, 0, 0);
    add(0, 1, 0,  3, 2, 0, 0, 0, 0);
    add(0, 1, 0,  5, 2, 0, 0, 0, 0);
    add(0, 0, 0,  1, 2, 0, 0, 0, 0);
    add(0, 1, 0,  2, 1, 0, 0, 0, 0);
    add(0, 1, 0,  1, 2, 0, 0, 0, 0);

    @(negedge clk);
    check("por", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      pif.pll_locked = vecs[i].lk;
      pif.retry_req  = vecs[i].rq;
      repeat (vecs[i].ncyc) @(negedge clk);
      pif.retry_req  = 1'b0;
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr, vecs[i].srn, vecs[i].flt, vecs[i].llc);
    end

    // Timeout path to FAULT, sticky, retry restarts with a full retry budget
    do_reset();
    run_to_fault("fault1");
    repeat (5) @(negedge clk);
    check("fault sticky", 3'd4, 1'b1, 1'b0, 1'b1, 8'd0);
    pif.retry_req = 1'b1;
    @(negedge clk);
    pif.retry_req = 1'b0;
    run_to_fault("fault2");

    // Async reset while stabilising
    do_reset();
    pif.pll_locked = 1'b1;
    wait_state(3'd2, 20, "reach stabilize");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset in stabilize", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Repeated loss in RUN with saturating counter
    wait_state(3'd3, 40, "reach run");
    for (int i = 1; i <= 300; i++) begin
      pif.pll_locked = 1'b0;
      repeat (3) @(negedge clk);
      exp_llc = (i > 255) ? 255 : i;
      check($sformatf("loss %0d", i), 3'd0, 1'b1, 1'b0, 1'b0, 8'(exp_llc));
      pif.pll_locked = 1'b1;
      wait_state(3'd3, 40, $sformatf("relock %0d", i));
    end
    check("run after 300 losses", 3'd3, 1'b0, 1'b1, 1'b0, 8'd255);

    pif.retry_req = 1'b1;
    @(negedge clk);
    pif.retry_req = 1'b0;
    @(negedge clk);
    check("retry ignored in run", 3'd3, 1'b0, 1'b1, 1'b0, 8'd255);

    // Async reset in RUN clears everything, including the loss counter
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset in run", 3'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
Sequences the on-chip PLL (27 MHz ext_clk in, sys_clk out) from power-up to a clean, stable system reset release. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock for a stability window before releasing sys_rst_n. It monitors lock continuously in RUN and re-sequences on loss. Runs entirely in the ext_clk domain. The sys_clk domain re-synchronises sys_rst_n locally.

Parameters:
PLL_RST_CYCLES, 16, ext_clk cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT, 27_000, max ext_clk cycles in WAIT_LOCK before an attempt fails (>=1)
STABLE_CYCLES, 2_700, consecutive synced-locked cycles required before release (>=1)
MAX_RETRIES, 3, failed attempts allowed before FAULT (0..15)
CNT_W, 16, width of internal cycle counter; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
ext_clk  in  1  board oscillator clock, 27 MHz
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to ext_clk
retry_req  in  1  single-cycle pulse; leaves FAULT and restarts sequencing
pll_reset  out  1  active-high reset to PLL
sys_rst_n  out  1  active-low system reset (1 = released)
fault  out  1  high while in FAULT
state  out  3  encoded FSM state for debug/LED
lock_loss_cnt  out  8  count of lock losses in RUN, saturating at 255

Behaviour:
- pll_locked passes through a 2-FF synchroniser (reset to 0). lk denotes the synced value. Raw-to-lk latency is 2 cycles.
- FSM encoding: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAULT=4. The state port mirrors the register.
- While rst_n is low (asynchronous): state=RESET_PLL, pll_reset=1, sys_rst_n=0, fault=0, lock_loss_cnt=0, retries=0, counter=0, sync FFs=0.
- RESET_PLL: pll_reset=1. Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK with counter cleared.
- WAIT_LOCK: pll_reset=0.
  - If lk=1, go to STABILIZE with counter cleared.
  - Otherwise, after LOCK_TIMEOUT cycles the attempt fails:
    - If retries < MAX_RETRIES: retries+1, go to RESET_PLL.
    - Else: go to FAULT.
- STABILIZE: counts consecutive lk=1 cycles.
  - If lk=0 on any cycle: counter clears and the FSM returns to WAIT_LOCK. The WAIT_LOCK timeout restarts; retries are unchanged.
  - After STABLE_CYCLES consecutive lk=1 cycles: go to RUN and clear retries.
- RUN: sys_rst_n=1.
  - On the first cycle with lk=0: sys_rst_n drops to 0 on that same clock edge (registered, 1-cycle latency from lk), lock_loss_cnt increments (saturating), and the FSM goes to RESET_PLL.
- FAULT: pll_reset=1, sys_rst_n=0, fault=1.
  - Sticky until rst_n is asserted or retry_req=1 is sampled.
  - retry_req clears retries and goes to RESET_PLL.
  - retry_req is ignored in every other state.
- All outputs are registered. sys_rst_n is 1 only in RUN. pll_reset is 1 only in RESET_PLL and FAULT.
- Simultaneous events:
  - WAIT_LOCK: if lk rises on the same cycle the timeout expires, lock wins (go to STABILIZE).
  - STABILIZE: if lk falls on the final stability cycle, the window is not met (go to WAIT_LOCK).
- Counter must not wrap. Elaboration must reject CNT_W too narrow for the parameters.
- rst_n asserted mid-sequence aborts immediately to reset values. No state survives.

Test Plan:
- Use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2 for every scenario below.
- Normal bring-up: release rst_n; raise pll_locked 10 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; sys_rst_n rises 2+8+1 cycles after the pll_locked edge (+-1); state sequence 0,1,2,3.
- Glitchy lock: locked high 5 cycles, low 1, then steady -> STABILIZE aborts to WAIT_LOCK; sys_rst_n releases only after 8 fresh consecutive locked cycles; retries unchanged.
- Timeout and fault: pll_locked held 0 -> three 4-cycle pll_reset pulses, each followed by 20 WAIT_LOCK cycles; then fault=1, state=4, pll_reset=1, sys_rst_n=0. A retry_req pulse then restarts at state 0 with retries=0.
- Loss in RUN: reach RUN, drop pll_locked -> sys_rst_n=0 within 3 cycles of the raw edge; lock_loss_cnt=1; pll_reset re-pulses for 4 cycles; relock returns to RUN. Repeat 300 times -> lock_loss_cnt stays at 255.
- Reset mid-operation and ignored requests:
  - Assert rst_n in STABILIZE and in RUN -> all outputs take reset values asynchronously, before the next edge.
  - Pulse retry_req in RUN -> no effect.
